// File: rtl/dm_unit.sv
// Word-organised data memory for the single-cycle MIPS core: combinational
// extended loads, byte/half/word stores on posedge, store trace and sticky error flags.
module dm_unit #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned IDX_W       = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        wr_valid,
    output logic [31:0] wr_pc,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic [31:0] store_cnt,
    output logic        misalign,
    output logic        oor
);

    localparam logic [31:0] ByteLimit = 32'(4 * DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] mem_d [DEPTH_WORDS];

    logic        wr_valid_q, wr_valid_d;
    logic [31:0] wr_pc_q, wr_pc_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [3:0]  wr_be_q, wr_be_d;
    logic [31:0] store_cnt_q, store_cnt_d;
    logic        misalign_q, misalign_d;
    logic        oor_q, oor_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic             in_range, aligned, is_word, is_half, is_byte, commit;
    logic [31:0]      cur_word, lane_data, wr_shift, merged;
    logic [3:0]       be;

    always_comb begin
        idx      = addr[IDX_W+1:2];
        off      = addr[1:0];
        in_range = addr < ByteLimit;
        is_word  = mem_op == 3'd0;
        is_half  = (mem_op == 3'd1) || (mem_op == 3'd2);
        is_byte  = (mem_op == 3'd3) || (mem_op == 3'd4);
        aligned  = is_word ? (off == 2'd0) : is_half ? !off[0] : is_byte;
        cur_word  = in_range ? mem_q[idx] : '0;
        // Shifting the addressed lane down to bit 0 serves both half and byte loads.
        lane_data = cur_word >> {off, 3'b000};

        rdata = '0;
        if (in_range && aligned) begin
            case (mem_op)
                3'd0:    rdata = cur_word;
                3'd1:    rdata = {{16{lane_data[15]}}, lane_data[15:0]};
                3'd2:    rdata = {16'h0, lane_data[15:0]};
                3'd3:    rdata = {{24{lane_data[7]}}, lane_data[7:0]};
                3'd4:    rdata = {24'h0, lane_data[7:0]};
                default: rdata = '0;
            endcase
        end

        be = is_word ? 4'b1111 : is_half ? (4'b0011 << off) :
             is_byte ? (4'b0001 << off) : 4'b0000;
        wr_shift = wdata << {off, 3'b000};
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? wr_shift[8*i +: 8] : cur_word[8*i +: 8];
        end
        commit = we && in_range && aligned;
    end

    always_comb begin
        mem_d       = mem_q;
        wr_valid_d  = commit;
        wr_pc_d     = wr_pc_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_be_d     = wr_be_q;
        store_cnt_d = store_cnt_q;
        if (commit) begin
            mem_d[idx]  = merged;
            wr_pc_d     = pc;
            wr_addr_d   = {addr[31:2], 2'b00};
            wr_data_d   = merged;
            wr_be_d     = be;
            store_cnt_d = store_cnt_q + 32'd1;
        end
        // mem_op is always driven, so the access is live every cycle.
        misalign_d = misalign_q | !aligned;
        oor_d      = oor_q | !in_range;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q       <= '{default: 32'h0};
            wr_valid_q  <= 1'b0;
            wr_pc_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_be_q     <= '0;
            store_cnt_q <= '0;
            misalign_q  <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_valid_q  <= wr_valid_d;
            wr_pc_q     <= wr_pc_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_be_q     <= wr_be_d;
            store_cnt_q <= store_cnt_d;
            misalign_q  <= misalign_d;
            oor_q       <= oor_d;
        end
    end

    assign wr_valid  = wr_valid_q;
    assign wr_pc     = wr_pc_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_be     = wr_be_q;
    assign store_cnt = store_cnt_q;
    assign misalign  = misalign_q;
    assign oor       = oor_q;

endmodule

// File: tb/tb_dm_unit.sv
// Bench for dm_unit: directed cases with literal expectations, then random traffic
// compared every cycle against a byte-level memory model.
module tb_dm_unit;

    localparam int Depth = 3072;
    localparam int Limit = 4 * Depth;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, pc;
    logic        we;
    logic [2:0]  mem_op;
    logic [31:0] rdata, wr_pc, wr_addr, wr_data, store_cnt;
    logic        wr_valid, misalign, oor;
    logic [3:0]  wr_be;

    dm_unit #(.DEPTH_WORDS(Depth), .IDX_W(12)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .mem_op(mem_op),
        .pc(pc), .rdata(rdata), .wr_valid(wr_valid), .wr_pc(wr_pc), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .store_cnt(store_cnt), .misalign(misalign),
        .oor(oor)
    );

    always #10 clk = ~clk;

    logic [31:0] mm [Depth];
    logic        m_valid, m_mis, m_oor;
    logic [31:0] m_pc, m_addr, m_data, m_cnt;
    logic [3:0]  m_be;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_misal(input logic [2:0] op, input logic [31:0] a);
        int sz = op_size(op);
        return (sz == 0) || ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] w, v;
        if (m_misal(op, a) || a >= Limit) return 32'h0;
        w = mm[a / 4];
        v = w >> (8 * (a % 4));
        case (op)
            3'd0:    return w;
            3'd1:    return (v[15] ? 32'hFFFF0000 : 32'h0) | (v & 32'hFFFF);
            3'd2:    return v & 32'hFFFF;
            3'd3:    return (v[7] ? 32'hFFFFFF00 : 32'h0) | (v & 32'hFF);
            default: return v & 32'hFF;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < Depth; i++) mm[i] = 32'h0;
        m_valid = 0; m_pc = 0; m_addr = 0; m_data = 0; m_be = 0; m_cnt = 0;
        m_mis = 0; m_oor = 0;
    endtask

    task automatic m_edge(input logic w, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] p);
        logic [31:0] word;
        logic [3:0]  lanes;
        int          sz, lane;
        if (m_misal(op, a)) m_mis = 1;
        if (a >= Limit) m_oor = 1;
        m_valid = 0;
        if (w && !m_misal(op, a) && a < Limit) begin
            sz = op_size(op);
            word = mm[a / 4];
            lanes = 0;
            for (int i = 0; i < sz; i++) begin
                lane = int'(a % 4) + i;
                word[8*lane +: 8] = d[8*i +: 8];
                lanes[lane] = 1'b1;
            end
            mm[a / 4] = word;
            m_valid = 1; m_pc = p; m_addr = a & 32'hFFFFFFFC;
            m_data = word; m_be = lanes; m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_regs();
        chk("wr_valid", {31'h0, wr_valid}, {31'h0, m_valid});
        chk("wr_pc", wr_pc, m_pc);
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
        chk("wr_be", {28'h0, wr_be}, {28'h0, m_be});
        chk("store_cnt", store_cnt, m_cnt);
        chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
        chk("oor", {31'h0, oor}, {31'h0, m_oor});
    endtask

    // One cycle: drive just after negedge, check rdata before posedge, check regs after.
    task automatic step(input logic w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] p, output logic [31:0] rd);
        we = w; mem_op = op; addr = a; wdata = d; pc = p;
        #3;
        rd = rdata;
        chk("rdata", rdata, m_load(op, a));
        @(posedge clk);
        m_edge(w, op, a, d, p);
        #1;
        check_regs();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] ra;
        logic [2:0]  rop;
        logic        rwe;
        int          sel;

        reset = 1'b0; we = 0; mem_op = 3'd0; addr = 0; wdata = 0; pc = 0;
        m_reset();
        @(negedge clk);
        check_regs();
        chk("reset rdata", rdata, 32'h0);
        reset = 1'b1;

        // sw then lw of the same word
        step(1, 3'd0, 32'h0, 32'h12345678, 32'h400, rd);
        chk("t1 wr_valid", {31'h0, wr_valid}, 32'h1);
        chk("t1 wr_be", {28'h0, wr_be}, 32'hF);
        chk("t1 store_cnt", store_cnt, 32'd1);
        step(0, 3'd0, 32'h0, 32'h0, 32'h404, rd);
        chk("t1 lw", rd, 32'h12345678);
        chk("t1 wr_valid drop", {31'h0, wr_valid}, 32'h0);

        // sb into lane 2
        step(1, 3'd3, 32'h2, 32'h000000AB, 32'h408, rd);
        chk("t2 wr_data", wr_data, 32'h12AB5678);
        chk("t2 wr_be", {28'h0, wr_be}, 32'h4);
        step(0, 3'd3, 32'h2, 32'h0, 32'h40C, rd);
        chk("t2 lb", rd, 32'hFFFFFFAB);
        step(0, 3'd4, 32'h2, 32'h0, 32'h410, rd);
        chk("t2 lbu", rd, 32'h000000AB);

        // sh into upper half of word 1
        step(1, 3'd1, 32'h6, 32'h00008001, 32'h414, rd);
        chk("t3 wr_be", {28'h0, wr_be}, 32'hC);
        step(0, 3'd1, 32'h6, 32'h0, 32'h418, rd);
        chk("t3 lh", rd, 32'hFFFF8001);
        step(0, 3'd2, 32'h6, 32'h0, 32'h41C, rd);
        chk("t3 lhu", rd, 32'h00008001);
        step(0, 3'd0, 32'h4, 32'h0, 32'h420, rd);
        chk("t3 lw", rd, 32'h80010000);

        // misaligned accesses
        step(1, 3'd0, 32'h3, 32'hDEADBEEF, 32'h424, rd);
        chk("t4 store_cnt", store_cnt, 32'd3);
        chk("t4 wr_valid", {31'h0, wr_valid}, 32'h0);
        chk("t4 misalign", {31'h0, misalign}, 32'h1);
        step(0, 3'd1, 32'h1, 32'h0, 32'h428, rd);
        chk("t4 lh rdata", rd, 32'h0);
        step(0, 3'd0, 32'h0, 32'h0, 32'h42C, rd);
        chk("t4 lw intact", rd, 32'h12AB5678);
        chk("t4 misalign held", {31'h0, misalign}, 32'h1);

        // range boundary
        step(1, 3'd0, 32'h3000, 32'h11111111, 32'h430, rd);
        chk("t5 oor", {31'h0, oor}, 32'h1);
        chk("t5 store_cnt", store_cnt, 32'd3);
        step(1, 3'd0, 32'h2FFC, 32'hCAFEF00D, 32'h434, rd);
        chk("t5 store_cnt inc", store_cnt, 32'd4);
        chk("t5 wr_addr", wr_addr, 32'h2FFC);
        step(0, 3'd0, 32'h2FFC, 32'h0, 32'h438, rd);
        chk("t5 lw", rd, 32'hCAFEF00D);

        // async reset in the middle of a store
        we = 1; mem_op = 3'd0; addr = 32'h0; wdata = 32'hFFFFFFFF; pc = 32'h43C;
        #3;
        reset = 1'b0;
        m_reset();
        #1;
        check_regs();
        chk("t6 rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        check_regs();
        @(negedge clk);
        reset = 1'b1;
        step(0, 3'd0, 32'h0, 32'h0, 32'h440, rd);
        chk("t6 lw 0", rd, 32'h0);
        step(0, 3'd0, 32'h4, 32'h0, 32'h444, rd);
        chk("t6 lw 4", rd, 32'h0);

        for (int n = 0; n < 2500; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      ra = $urandom_range(0, 63);
            else if (sel < 8) ra = 32'h2FF0 + $urandom_range(0, 31);
            else              ra = $urandom;
            rwe = $urandom_range(0, 1) == 1;
            rop = rwe ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
            step(rwe, rop, ra, $urandom, $urandom, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
